// File: rtl/regfile_scoreboard_pkg.sv
// Shared defaults and the byte-merge helper used by both the storage write and the bypass paths.
// Callers widen their operands to MERGE_W and truncate the result back to their own WIDTH.
package regfile_pkg;

   localparam int DEF_WIDTH  = 32;
   localparam int DEF_DEPTH  = 32;
   localparam int DEF_ADDR_W = 5;
   localparam int MERGE_W    = 256;
   localparam int MERGE_B    = MERGE_W / 8;

   function automatic logic [MERGE_W-1:0] merge_bytes(
      input logic [MERGE_W-1:0] old_val,
      input logic [MERGE_W-1:0] new_val,
      input logic [MERGE_B-1:0] mask
   );
      logic [MERGE_W-1:0] res;
      res = old_val;
      for (int i = 0; i < MERGE_B; i++) begin
         if (mask[i]) begin
            res[8*i +: 8] = new_val[8*i +: 8];
         end else begin
            res[8*i +: 8] = old_val[8*i +: 8];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback-side bus of the register file: write port, two read ports and the scoreboard.
interface regfile_scoreboard_if
   import regfile_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int ADDR_W = DEF_ADDR_W
);
   logic                 WrEn;
   logic [ADDR_W-1:0]    Aw;
   logic [WIDTH-1:0]     Dw;
   logic [WIDTH/8-1:0]   ByteEn;
   logic [ADDR_W-1:0]    Aa;
   logic [ADDR_W-1:0]    Ab;
   logic [WIDTH-1:0]     Da;
   logic [WIDTH-1:0]     Db;
   logic                 IssueEn;
   logic [ADDR_W-1:0]    IssueAddr;
   logic                 BusyA;
   logic                 BusyB;
   logic [ADDR_W:0]      PendCount;

   modport master (
      output WrEn, Aw, Dw, ByteEn, Aa, Ab, IssueEn, IssueAddr,
      input  Da, Db, BusyA, BusyB, PendCount
   );

   modport slave (
      input  WrEn, Aw, Dw, ByteEn, Aa, Ab, IssueEn, IssueAddr,
      output Da, Db, BusyA, BusyB, PendCount
   );
endinterface

// File: rtl/regfile_scoreboard_pend.sv
// Per-register pending-write bits and the running count of pending registers.
// Writes clear first, then an issue sets, so a same-cycle issue to the written register wins.
module regfile_scoreboard_pend
   import regfile_pkg::*;
#(
   parameter int DEPTH    = DEF_DEPTH,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              WrEn,
   input  logic [ADDR_W-1:0] Aw,
   input  logic              IssueEn,
   input  logic [ADDR_W-1:0] IssueAddr,
   input  logic [ADDR_W-1:0] Aa,
   input  logic [ADDR_W-1:0] Ab,
   output logic              BusyA,
   output logic              BusyB,
   output logic [ADDR_W:0]   PendCount
);
   localparam bit               ZR      = (ZERO_REG != 0);
   localparam logic [ADDR_W-1:0] A_ZERO = {ADDR_W{1'b0}};
   localparam logic [ADDR_W:0]  CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

   logic [DEPTH-1:0] pend_q, pend_d;
   logic [ADDR_W:0]  cnt_q, cnt_d;
   logic             iss_s, inc_s, dec_s;

   // Next pend vector and count; the count tracks only bits that actually flip.
   always_comb begin
      iss_s  = IssueEn && !(ZR && (IssueAddr == A_ZERO));
      inc_s  = iss_s && !pend_q[IssueAddr];
      dec_s  = WrEn && pend_q[Aw] && !(iss_s && (IssueAddr == Aw));
      pend_d = pend_q;
      if (WrEn) begin
         pend_d[Aw] = 1'b0;
      end else begin
         pend_d[Aw] = pend_q[Aw];
      end
      if (iss_s) begin
         pend_d[IssueAddr] = 1'b1;
      end else begin
         pend_d[IssueAddr] = pend_d[IssueAddr];
      end
      case ({inc_s, dec_s})
         2'b10:   cnt_d = cnt_q + CNT_ONE;
         2'b01:   cnt_d = cnt_q - CNT_ONE;
         default: cnt_d = cnt_q;
      endcase
   end

   // Scoreboard state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q <= {DEPTH{1'b0}};
         cnt_q  <= {(ADDR_W+1){1'b0}};
      end else begin
         pend_q <= pend_d;
         cnt_q  <= cnt_d;
      end
   end

   assign BusyA     = pend_q[Aa] && !(WrEn && (Aw == Aa)) && !(ZR && (Aa == A_ZERO));
   assign BusyB     = pend_q[Ab] && !(WrEn && (Aw == Ab)) && !(ZR && (Ab == A_ZERO));
   assign PendCount = cnt_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// WIDTH x DEPTH register file with byte-masked write, write-through bypass on both
// combinational read ports, and a pending-write scoreboard for hazard detection.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int ZERO_REG = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   regfile_scoreboard_if.slave   bus
);
   localparam bit                ZR     = (ZERO_REG != 0);
   localparam logic [ADDR_W-1:0] A_ZERO = {ADDR_W{1'b0}};

   logic [WIDTH-1:0] regs_q [DEPTH];
   logic [WIDTH-1:0] regs_d [DEPTH];
   logic [WIDTH-1:0] da_s, db_s;

   // Storage update; a write to the hard-wired zero register is dropped.
   always_comb begin
      regs_d = regs_q;
      if (bus.WrEn && !(ZR && (bus.Aw == A_ZERO))) begin
         regs_d[bus.Aw] = WIDTH'(merge_bytes(MERGE_W'(regs_q[bus.Aw]), MERGE_W'(bus.Dw),
                                             MERGE_B'(bus.ByteEn)));
      end else begin
         regs_d[bus.Aw] = regs_q[bus.Aw];
      end
   end

   // Register array.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs_q <= '{default: {WIDTH{1'b0}}};
      end else begin
         regs_q <= regs_d;
      end
   end

   // Port A read; zero register overrides the bypass.
   always_comb begin
      if (ZR && (bus.Aa == A_ZERO)) begin
         da_s = {WIDTH{1'b0}};
      end else if (bus.WrEn && (bus.Aw == bus.Aa)) begin
         da_s = WIDTH'(merge_bytes(MERGE_W'(regs_q[bus.Aa]), MERGE_W'(bus.Dw),
                                   MERGE_B'(bus.ByteEn)));
      end else begin
         da_s = regs_q[bus.Aa];
      end
   end

   // Port B read; same rules as port A.
   always_comb begin
      if (ZR && (bus.Ab == A_ZERO)) begin
         db_s = {WIDTH{1'b0}};
      end else if (bus.WrEn && (bus.Aw == bus.Ab)) begin
         db_s = WIDTH'(merge_bytes(MERGE_W'(regs_q[bus.Ab]), MERGE_W'(bus.Dw),
                                   MERGE_B'(bus.ByteEn)));
      end else begin
         db_s = regs_q[bus.Ab];
      end
   end

   assign bus.Da = da_s;
   assign bus.Db = db_s;

   regfile_scoreboard_pend #(
      .DEPTH    (DEPTH),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
   ) u_pend (
      .clk       (clk),
      .rst_n     (rst_n),
      .WrEn      (bus.WrEn),
      .Aw        (bus.Aw),
      .IssueEn   (bus.IssueEn),
      .IssueAddr (bus.IssueAddr),
      .Aa        (bus.Aa),
      .Ab        (bus.Ab),
      .BusyA     (bus.BusyA),
      .BusyB     (bus.BusyB),
      .PendCount (bus.PendCount)
   );

endmodule
